// File: rtl/if_id_decode_stage_pkg.sv
// rv_pkg: shared RV32I front-end definitions.
//   imm_sel_e   : ImmGen immediate-format select
//   OP_*        : base opcodes recognised by the pre-decoder
//   id_entry_t  : one decoded IF->ID entry as held in the stage registers
//   ENTRY_RST   : reset image of an entry (no immediate, not illegal)
package rv_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic [2:0] {
    IMM_S    = 3'd0,
    IMM_I    = 3'd1,
    IMM_B    = 3'd2,
    IMM_J    = 3'd3,
    IMM_U    = 3'd4,
    IMM_NONE = 3'd7
  } imm_sel_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [24:0]     imm_field;
    imm_sel_e        imm_sel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic            illegal;
  } id_entry_t;

  localparam id_entry_t ENTRY_RST = '{
    pc:        '0,
    imm_field: '0,
    imm_sel:   IMM_NONE,
    rs1:       '0,
    rs2:       '0,
    rd:        '0,
    opcode:    '0,
    illegal:   1'b0
  };

endpackage

// File: rtl/if_id_decode_stage_predecode.sv
// rv_predecode: combinational RV32I pre-decoder.
//   inst       in   32  instruction word
//   imm_field  out  25  inst[31:7], raw ImmGen operand
//   imm_sel    out  3   immediate format for ImmGen
//   rs1/rs2/rd out  5   register specifiers
//   opcode     out  7   inst[6:0]
//   illegal    out  1   opcode not in the supported RV32I base set
module rv_predecode
  import rv_pkg::*;
(
  input  logic [31:0] inst,
  output logic [24:0] imm_field,
  output imm_sel_e    imm_sel,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [6:0]  opcode,
  output logic        illegal
);

  assign imm_field = inst[31:7];
  assign rs1       = inst[19:15];
  assign rs2       = inst[24:20];
  assign rd        = inst[11:7];
  assign opcode    = inst[6:0];

  // Every listed opcode ends in 2'b11, so a compressed/invalid low pair
  // always falls through to the default arm and is flagged illegal.
  always_comb begin
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR:   imm_sel = IMM_I;
      OP_STORE:                   imm_sel = IMM_S;
      OP_BRANCH:                  imm_sel = IMM_B;
      OP_JAL:                     imm_sel = IMM_J;
      OP_LUI, OP_AUIPC:           imm_sel = IMM_U;
      OP_REG, OP_FENCE, OP_SYSTEM: imm_sel = IMM_NONE;
      default:                    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_decode_stage.sv
// if_id_decode_stage: IF->ID pipeline stage with a 2-entry skid buffer.
//   clk, rst       clock, synchronous active-high reset
//   if_valid/if_ready, if_pc, if_inst   fetch-side handshake and payload
//   flush          kill all held entries (redirect)
//   id_valid/id_ready                   EX-side handshake
//   id_pc, id_imm_field, id_imm_sel, id_rs1, id_rs2, id_rd,
//   id_opcode, id_illegal               pre-decoded output entry
// Main register M drives the outputs; skid register S catches an accept
// that arrives while M is stalled. if_ready is registered as !S.valid.
module if_id_decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [ILEN-1:0] if_inst,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [24:0]     id_imm_field,
  output logic [2:0]      id_imm_sel,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [6:0]      id_opcode,
  output logic            id_illegal
);

  id_entry_t in_entry;
  id_entry_t m_q, m_d;
  id_entry_t s_q, s_d;
  logic      m_v_q, m_v_d;
  logic      s_v_q, s_v_d;
  logic      rdy_q;
  logic      accept;
  logic      retire;

  logic [24:0] dec_imm_field;
  imm_sel_e    dec_imm_sel;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [6:0]  dec_opcode;
  logic        dec_illegal;

  rv_predecode u_predecode (
    .inst      (if_inst),
    .imm_field (dec_imm_field),
    .imm_sel   (dec_imm_sel),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rd        (dec_rd),
    .opcode    (dec_opcode),
    .illegal   (dec_illegal)
  );

  always_comb begin
    in_entry           = ENTRY_RST;
    in_entry.pc        = if_pc;
    in_entry.imm_field = dec_imm_field;
    in_entry.imm_sel   = dec_imm_sel;
    in_entry.rs1       = dec_rs1;
    in_entry.rs2       = dec_rs2;
    in_entry.rd        = dec_rd;
    in_entry.opcode    = dec_opcode;
    in_entry.illegal   = dec_illegal;
  end

  assign accept = if_valid && rdy_q;
  assign retire = m_v_q && id_ready;

  // With S valid, rdy_q is low, so the "S refills from input" arm below is
  // unreachable in practice; it is kept so occupancy stays correct if the
  // ready policy is ever relaxed.
  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (!m_v_q || retire) begin
      if (s_v_q) begin
        m_d   = s_q;
        m_v_d = 1'b1;
        s_v_d = accept;
        if (accept) begin
          s_d = in_entry;
        end
      end else if (accept) begin
        m_d   = in_entry;
        m_v_d = 1'b1;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (accept) begin
      s_d   = in_entry;
      s_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q   <= ENTRY_RST;
      s_q   <= ENTRY_RST;
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
      rdy_q <= !s_v_d;
    end
  end

  assign if_ready     = rdy_q;
  assign id_valid     = m_v_q;
  assign id_pc        = m_q.pc;
  assign id_imm_field = m_q.imm_field;
  assign id_imm_sel   = m_q.imm_sel;
  assign id_rs1       = m_q.rs1;
  assign id_rs2       = m_q.rs2;
  assign id_rd        = m_q.rd;
  assign id_opcode    = m_q.opcode;
  assign id_illegal   = m_q.illegal;

endmodule
